mips_control_unit: RTL and testbench

- Main controller FSM for the multi-cycle (non-pipelined) MIPS datapath; sits directly upstream of the datapath and drives all of its enables and mux selects.
- Decodes opcode/funct from the instruction register plus the ALU zero flag.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi, j; any other encoding is flagged illegal and skipped.

---
 rtl/mips_control_unit.sv | 177 +++++++++++++++++
 tb/tb_mips_control_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips_control_unit.sv
// Main controller FSM for the multi-cycle MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath controls.
module mips_control_unit #(
   parameter int OPCODE_WIDTH   = 6,
   parameter int FUNCT_WIDTH    = 6,
   parameter int ALU_CTRL_WIDTH = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [OPCODE_WIDTH-1:0]   opcode,
   input  logic [FUNCT_WIDTH-1:0]    funct,
   input  logic                      zero,
   output logic                      pc_en,
   output logic                      ir_write,
   output logic                      iord,
   output logic                      mem_write,
   output logic                      reg_write,
   output logic                      reg_dst,
   output logic                      mem_to_reg,
   output logic                      alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [ALU_CTRL_WIDTH-1:0] alu_control,
   output logic [1:0]                pc_src,
   output logic                      illegal_instr,
   output logic [3:0]                state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
   localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);

   localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
   localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
   localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
   localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
   localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);

   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b010);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b110);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b000);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b001);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b111);

   state_t r_state;
   state_t w_next;

   function automatic logic f_funct_ok(input logic [FUNCT_WIDTH-1:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

   function automatic logic [ALU_CTRL_WIDTH-1:0] f_alu_ctrl(input logic [FUNCT_WIDTH-1:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      pc_en         = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_control   = ALU_ADD;
      pc_src        = 2'b00;
      illegal_instr = 1'b0;
      w_next        = S_FETCH;
      case (r_state)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            alu_src_b = 2'b01;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            // Unsupported encodings fall back to FETCH; PC already points past them
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE: begin
                  if (f_funct_ok(funct)) w_next = S_EXECUTE;
                  else                   illegal_instr = 1'b1;
               end
               OP_BEQ:  w_next = S_BRANCH;
               OP_ADDI: w_next = S_ADDIEX;
               OP_J:    w_next = S_JUMP;
               default: illegal_instr = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            iord   = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a   = 1'b1;
            alu_control = f_alu_ctrl(funct);
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            pc_en       = zero;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = S_ADDIWB;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
      // Reset abandons the current instruction without any architectural update
      if (rst) begin
         pc_en         = 1'b0;
         ir_write      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         illegal_instr = 1'b0;
      end
   end

   assign state = r_state;

endmodule

// File: tb/tb_mips_control_unit.sv
// Scoreboard bench for mips_control_unit: stimulus queues hand-computed control
// vectors per cycle, a monitor compares them against the DUT on the falling edge.
module tb_mips_control_unit;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] pc_src;
   logic       illegal_instr;
   logic [3:0] state;

   mips_control_unit #(.OPCODE_WIDTH(6), .FUNCT_WIDTH(6), .ALU_CTRL_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .pc_src(pc_src), .illegal_instr(illegal_instr), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [19:0] exp_q[$];
   string       name_q[$];
   logic        stim_done = 1'b0;

   // Layout: state, pc_en, ir_write, iord, mem_write, reg_write, reg_dst,
   // mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src, illegal_instr
   function automatic logic [19:0] mk(input logic [3:0] st, input logic pe, ir, io, mw, rw,
                                      rd, m2r, asa, input logic [1:0] asb,
                                      input logic [2:0] ac, input logic [1:0] ps,
                                      input logic il);
      return {st, pe, ir, io, mw, rw, rd, m2r, asa, asb, ac, ps, il};
   endfunction

   logic [19:0] w_act;
   assign w_act = {state, pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_control, pc_src, illegal_instr};

   logic [19:0] V_F, V_D, V_DILL, V_MA, V_MR, V_MWB, V_MW, V_ALUWB, V_AE, V_AW, V_J, V_RST0;
   logic [19:0] V_EADD, V_ESUB, V_EAND, V_EOR, V_ESLT, V_BR1, V_BR0;
   initial begin
      V_F     = mk(4'd0, 1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0);
      V_RST0  = mk(4'd0, 0,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0);
      V_D     = mk(4'd1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0);
      V_DILL  = mk(4'd1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 1);
      V_MA    = mk(4'd2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0);
      V_MR    = mk(4'd3, 0,0,1,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0);
      V_MWB   = mk(4'd4, 0,0,0,0,1,0,1,0, 2'b00, 3'b010, 2'b00, 0);
      V_MW    = mk(4'd5, 0,0,1,1,0,0,0,0, 2'b00, 3'b010, 2'b00, 0);
      V_EADD  = mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0);
      V_ESUB  = mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b00, 0);
      V_EAND  = mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b000, 2'b00, 0);
      V_EOR   = mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b001, 2'b00, 0);
      V_ESLT  = mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b111, 2'b00, 0);
      V_ALUWB = mk(4'd7, 0,0,0,0,1,1,0,0, 2'b00, 3'b010, 2'b00, 0);
      V_BR1   = mk(4'd8, 1,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0);
      V_BR0   = mk(4'd8, 0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0);
      V_AE    = mk(4'd9, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0);
      V_AW    = mk(4'd10,0,0,0,0,1,0,0,0, 2'b00, 3'b010, 2'b00, 0);
      V_J     = mk(4'd11,1,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b10, 0);
   end

   // One clock cycle of stimulus plus the control vector expected in that cycle
   task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic r, input logic [19:0] e);
      @(posedge clk);
      #1;
      opcode = op;
      funct  = fn;
      zero   = z;
      rst    = r;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic rtype(input string nm, input logic [5:0] fn, input logic [19:0] ex);
      cyc({nm, "_f"}, 6'b000000, fn, 0, 0, V_F);
      cyc({nm, "_d"}, 6'b000000, fn, 0, 0, V_D);
      cyc({nm, "_ex"}, 6'b000000, fn, 0, 0, ex);
      cyc({nm, "_wb"}, 6'b000000, fn, 0, 0, V_ALUWB);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [19:0] e;
         string       nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_tests++;
         if (w_act !== e) begin
            n_fail++;
            $display("FAIL %s: got %05h (state %0d) expected %05h (state %0d)",
                     nm, w_act, w_act[19:16], e, e[19:16]);
         end
      end
   end

   initial begin
      rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
      repeat (2) @(posedge clk);
      cyc("rst_state", 6'b000000, 6'b000000, 0, 1, V_RST0);
      // lw
      cyc("lw_f",  6'b100011, 0, 0, 0, V_F);
      cyc("lw_d",  6'b100011, 0, 0, 0, V_D);
      cyc("lw_ma", 6'b100011, 0, 0, 0, V_MA);
      cyc("lw_mr", 6'b100011, 0, 0, 0, V_MR);
      cyc("lw_wb", 6'b100011, 0, 0, 0, V_MWB);
      // R-type
      rtype("sub", 6'b100010, V_ESUB);
      rtype("slt", 6'b101010, V_ESLT);
      rtype("add", 6'b100000, V_EADD);
      rtype("and", 6'b100100, V_EAND);
      rtype("or",  6'b100101, V_EOR);
      // beq taken and not taken
      cyc("beq1_f", 6'b000100, 0, 0, 0, V_F);
      cyc("beq1_d", 6'b000100, 0, 0, 0, V_D);
      cyc("beq1_br", 6'b000100, 0, 1, 0, V_BR1);
      cyc("beq0_f", 6'b000100, 0, 0, 0, V_F);
      cyc("beq0_d", 6'b000100, 0, 1, 0, V_D);
      cyc("beq0_br", 6'b000100, 0, 0, 0, V_BR0);
      // sw
      cyc("sw_f",  6'b101011, 0, 0, 0, V_F);
      cyc("sw_d",  6'b101011, 0, 0, 0, V_D);
      cyc("sw_ma", 6'b101011, 0, 0, 0, V_MA);
      cyc("sw_mw", 6'b101011, 0, 0, 0, V_MW);
      // addi
      cyc("addi_f",  6'b001000, 0, 0, 0, V_F);
      cyc("addi_d",  6'b001000, 0, 0, 0, V_D);
      cyc("addi_ex", 6'b001000, 0, 0, 0, V_AE);
      cyc("addi_wb", 6'b001000, 0, 0, 0, V_AW);
      // j
      cyc("j_f", 6'b000010, 0, 0, 0, V_F);
      cyc("j_d", 6'b000010, 0, 0, 0, V_D);
      cyc("j_j", 6'b000010, 0, 0, 0, V_J);
      // illegal opcode, then illegal R-type funct
      cyc("ill_op_f", 6'b111111, 0, 0, 0, V_F);
      cyc("ill_op_d", 6'b111111, 0, 0, 0, V_DILL);
      cyc("ill_fn_f", 6'b000000, 6'b000000, 0, 0, V_F);
      cyc("ill_fn_d", 6'b000000, 6'b000000, 0, 0, V_DILL);
      cyc("ill_ret_f", 6'b100011, 0, 0, 0, V_F);
      // reset in MEMREAD: next cycle is FETCH with no register write
      cyc("rmr_d",  6'b100011, 0, 0, 0, V_D);
      cyc("rmr_ma", 6'b100011, 0, 0, 0, V_MA);
      cyc("rmr_mr", 6'b100011, 0, 0, 1, V_MR);
      cyc("rmr_f",  6'b100011, 0, 0, 0, V_F);
      // two-cycle reset from MEMADR
      cyc("rma_d",  6'b101011, 0, 0, 0, V_D);
      cyc("rma_ma", 6'b101011, 0, 0, 1, V_MA);
      cyc("rma_r0", 6'b101011, 0, 0, 1, V_RST0);
      cyc("rma_f",  6'b101011, 0, 0, 0, V_F);
      cyc("rma_d2", 6'b101011, 0, 0, 0, V_D);
      repeat (2) @(posedge clk);
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: stimulus incomplete, expected done");
      $fatal(1, "timeout");
   end

endmodule
